// File: rtl/sfx_sequencer.sv
// rtl/sfx_sequencer.sv - Priority sound-effect sequencer driving a 1-bit square-wave speaker
// Plays a fixed multi-step tone pattern from internal ROM for the highest-priority event.
module sfx_sequencer #(
  parameter int CLK_HZ    = 25_000_000,
  parameter int US_DIV    = CLK_HZ / 1_000_000,
  parameter int US_PER_MS = 1000
) (
  input  logic       Clk,
  input  logic       sys_reset,
  input  logic       flap_trig,
  input  logic       score_trig,
  input  logic       crash_trig,
  input  logic       mute,
  output logic       Speaker,
  output logic       busy,
  output logic [1:0] sfx_id
);

  localparam int UW = (US_DIV > 1) ? $clog2(US_DIV) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, PLAY = 2'd2} state_t;

  state_t        state, state_n;
  logic [1:0]    cur_id, cur_id_n;
  logic [1:0]    step, step_n;
  logic [11:0]   hp, hp_n;
  logic [7:0]    dur, dur_n;
  logic [UW-1:0] us_cnt, us_cnt_n;
  logic [11:0]   half_cnt, half_cnt_n;
  logic [9:0]    ms_sub, ms_sub_n;
  logic [7:0]    ms_cnt, ms_cnt_n;
  logic          phase, phase_n;
  logic          spk, spk_n;
  logic          busy_r, busy_n;

  logic [1:0]    trig_id;
  logic          accept;
  logic          us_tick, ms_tick, step_end;
  logic [20:0]   rom_word;
  logic          rom_last;
  logic [11:0]   rom_hp;
  logic [7:0]    rom_dur;

  // Word layout: {last step, half-period in us, duration in ms}
  function automatic logic [20:0] rom(input logic [1:0] id, input logic [1:0] idx);
    case ({id, idx})
      4'b01_00: rom = {1'b0, 12'd600,  8'd30};
      4'b01_01: rom = {1'b1, 12'd400,  8'd30};
      4'b10_00: rom = {1'b0, 12'd500,  8'd60};
      4'b10_01: rom = {1'b0, 12'd333,  8'd60};
      4'b10_10: rom = {1'b1, 12'd250,  8'd120};
      4'b11_00: rom = {1'b0, 12'd2000, 8'd80};
      4'b11_01: rom = {1'b0, 12'd0,    8'd40};
      4'b11_10: rom = {1'b1, 12'd3000, 8'd200};
      default:  rom = {1'b1, 12'd0,    8'd1};
    endcase
  endfunction

  always_comb begin
    trig_id = 2'd0;
    if (crash_trig)      trig_id = 2'd3;
    else if (score_trig) trig_id = 2'd2;
    else if (flap_trig)  trig_id = 2'd1;
  end

  assign accept   = (trig_id != 2'd0) && (trig_id >= cur_id);
  assign rom_word = rom(cur_id, step);
  assign rom_last = rom_word[20];
  assign rom_hp   = rom_word[19:8];
  assign rom_dur  = rom_word[7:0];
  assign us_tick  = (state == PLAY) && (us_cnt == UW'(US_DIV - 1));
  assign ms_tick  = us_tick && (ms_sub == 10'(US_PER_MS - 1));
  assign step_end = ms_tick && ((ms_cnt + 8'd1) == dur);

  always_ff @(posedge Clk or negedge sys_reset) begin
    if (!sys_reset) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (accept) begin
      state_n = LOAD;
    end else begin
      case (state)
        LOAD:    state_n = PLAY;
        PLAY:    if (step_end) state_n = rom_last ? IDLE : LOAD;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    cur_id_n   = cur_id;
    step_n     = step;
    hp_n       = hp;
    dur_n      = dur;
    us_cnt_n   = us_cnt;
    half_cnt_n = half_cnt;
    ms_sub_n   = ms_sub;
    ms_cnt_n   = ms_cnt;
    phase_n    = phase;
    if (accept) begin
      cur_id_n = trig_id;
      step_n   = 2'd0;
      phase_n  = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          hp_n       = rom_hp;
          dur_n      = rom_dur;
          us_cnt_n   = '0;
          half_cnt_n = '0;
          ms_sub_n   = '0;
          ms_cnt_n   = '0;
          phase_n    = (rom_hp != 12'd0);
        end
        PLAY: begin
          us_cnt_n = us_tick ? '0 : us_cnt + UW'(1);
          if (us_tick) begin
            if (ms_tick) begin
              ms_sub_n = '0;
              ms_cnt_n = ms_cnt + 8'd1;
            end else begin
              ms_sub_n = ms_sub + 10'd1;
            end
            if (hp != 12'd0) begin
              if ((half_cnt + 12'd1) == hp) begin
                half_cnt_n = '0;
                phase_n    = ~phase;
              end else begin
                half_cnt_n = half_cnt + 12'd1;
              end
            end
          end
          if (step_end) begin
            if (rom_last) begin
              cur_id_n = 2'd0;
              step_n   = 2'd0;
              phase_n  = 1'b0;
            end else begin
              step_n = step + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
    // mute only gates the output register; phase keeps running underneath
    spk_n  = phase_n & ~mute;
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge Clk or negedge sys_reset) begin
    if (!sys_reset) begin
      cur_id   <= '0;
      step     <= '0;
      hp       <= '0;
      dur      <= '0;
      us_cnt   <= '0;
      half_cnt <= '0;
      ms_sub   <= '0;
      ms_cnt   <= '0;
      phase    <= 1'b0;
      spk      <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      cur_id   <= cur_id_n;
      step     <= step_n;
      hp       <= hp_n;
      dur      <= dur_n;
      us_cnt   <= us_cnt_n;
      half_cnt <= half_cnt_n;
      ms_sub   <= ms_sub_n;
      ms_cnt   <= ms_cnt_n;
      phase    <= phase_n;
      spk      <= spk_n;
      busy_r   <= busy_n;
    end
  end

  assign Speaker = spk;
  assign busy    = busy_r;
  assign sfx_id  = cur_id;

endmodule
